// File: rtl/fb_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_arbiter_if
// Purpose : bundles the CPU load/store handshake and the single-port
//           framebuffer RAM bus that fb_arbiter sits between.
// Signals :
//   cpu_req   CPU access request, held until cpu_ack
//   cpu_we    1=write, 0=read; stable while cpu_req is high
//   cpu_addr  linear framebuffer address (ADDR_W bits)
//   cpu_wdata write data
//   cpu_rdata read data, valid while cpu_ack is high
//   cpu_ack   one-cycle completion pulse
//   ram_addr  RAM address (ADDR_W bits)
//   ram_we    RAM write enable
//   ram_wdata RAM write data
//   ram_rdata RAM read data, one cycle after ram_addr
// Modports:
//   slave  - the arbiter side (consumes CPU requests, drives the RAM)
//   master - the environment side (CPU requester plus RAM model)
// -----------------------------------------------------------------------------
interface fb_arbiter_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
// Purpose : shares one single-port synchronous framebuffer RAM between the VGA
//           pixel fetch (absolute priority) and a CPU load/store port. Screen
//           coordinates are downscaled by 2**SCALE into framebuffer addresses;
//           color_out follows vga_x/vga_y with a fixed 2-cycle latency. The CPU
//           is granted only in cycles without a pixel fetch.
// Ports   :
//   clock        pixel clock
//   reset_n      synchronous reset, active low
//   vga_x/vga_y  next pixel coordinates from the VGA driver
//   pix_valid    (vga_x, vga_y) lies in the active region
//   color_out    registered RRRGGGBB pixel color
//   stall_count  CPU stall cycles (only counts with FB_PERF_CNT_EN)
//   bus          CPU handshake + RAM bus (fb_arbiter_if.slave)
// Build option:
//   FB_PERF_CNT_EN  when defined, stall_count counts cycles in which a CPU
//                   request waits in IDLE without a grant (saturating);
//                   otherwise stall_count is tied to zero.
// -----------------------------------------------------------------------------
module fb_arbiter #(
    parameter int unsigned FB_W   = 160,
    parameter int unsigned FB_H   = 120,
    parameter int unsigned SCALE  = 2,
    parameter int unsigned ADDR_W = 15
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [9:0]         vga_x,
    input  logic [9:0]         vga_y,
    input  logic               pix_valid,
    output logic [7:0]         color_out,
    output logic [15:0]        stall_count,
    fb_arbiter_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE,
        WR_ACK,
        RD_WAIT,
        RD_ACK
    } state_t;

    localparam int unsigned FB_SIZE  = FB_W * FB_H;
    localparam logic [9:0]  SUB_MASK = 10'((1 << SCALE) - 1);

    state_t            state_q, state_d;
    logic              p1_valid_q, p1_valid_d;
    logic              p1_fetch_q, p1_fetch_d;
    logic [7:0]        hold_q, hold_d;
    logic [7:0]        color_q, color_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              oob_q, oob_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_d;

    logic [9:0]        sx, sy;
    logic              in_range;
    logic              fetch;
    logic [ADDR_W-1:0] fetch_addr;
    logic              cpu_in_range;
    logic              grant;

    always_comb begin
        state_d    = state_q;
        p1_valid_d = 1'b0;
        p1_fetch_d = 1'b0;
        hold_d     = hold_q;
        color_d    = 8'h00;
        rdata_d    = rdata_q;
        oob_d      = oob_q;
        ram_addr_d = ram_addr_q;
        ram_we_d   = 1'b0;

        // Framebuffer coordinates and fetch-slot decode
        sx           = vga_x >> SCALE;
        sy           = vga_y >> SCALE;
        in_range     = (32'(sx) < FB_W) && (32'(sy) < FB_H);
        fetch        = pix_valid && ((vga_x & SUB_MASK) == '0) && in_range;
        fetch_addr   = ADDR_W'(sy) * ADDR_W'(FB_W) + ADDR_W'(sx);
        cpu_in_range = 32'(bus.cpu_addr) < FB_SIZE;

        // Reset gates the grant so that a request held during reset never
        // reaches the RAM as a write.
        grant = reset_n && (state_q == IDLE) && bus.cpu_req && !fetch;

        // RAM port mux: pixel fetch first, then a granted CPU access;
        // with no access the address simply holds.
        if (fetch) begin
            ram_addr_d = fetch_addr;
        end else if (grant) begin
            ram_addr_d = bus.cpu_addr;
            ram_we_d   = bus.cpu_we && cpu_in_range;
        end

        // Pixel pipeline: stage 1 tracks the request, stage 2 is color_out.
        // ram_rdata for a fetch arrives while the fetch flag sits in stage 1.
        p1_valid_d = pix_valid && in_range;
        p1_fetch_d = fetch;
        if (p1_fetch_q) begin
            hold_d = bus.ram_rdata;
        end
        if (p1_valid_q) begin
            color_d = p1_fetch_q ? bus.ram_rdata : hold_q;
        end

        // CPU access FSM
        case (state_q)
            IDLE: begin
                if (grant) begin
                    oob_d   = !cpu_in_range;
                    state_d = bus.cpu_we ? WR_ACK : RD_WAIT;
                end
            end
            WR_ACK: begin
                state_d = IDLE;
            end
            RD_WAIT: begin
                rdata_d = oob_q ? 8'h00 : bus.ram_rdata;
                state_d = RD_ACK;
            end
            RD_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            p1_valid_q <= 1'b0;
            p1_fetch_q <= 1'b0;
            hold_q     <= 8'h00;
            color_q    <= 8'h00;
            rdata_q    <= 8'h00;
            oob_q      <= 1'b0;
            ram_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            p1_valid_q <= p1_valid_d;
            p1_fetch_q <= p1_fetch_d;
            hold_q     <= hold_d;
            color_q    <= color_d;
            rdata_q    <= rdata_d;
            oob_q      <= oob_d;
            ram_addr_q <= ram_addr_d;
        end
    end

`ifdef FB_PERF_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (bus.cpu_req && (state_q == IDLE) && !grant && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

    assign color_out     = color_q;
    assign bus.cpu_ack   = (state_q == WR_ACK) || (state_q == RD_ACK);
    assign bus.cpu_rdata = rdata_q;
    assign bus.ram_addr  = ram_addr_d;
    assign bus.ram_we    = ram_we_d;
    assign bus.ram_wdata = bus.cpu_wdata;

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

    logic clock = 1'b0;
    always #20 clock = ~clock;

    logic        reset_n;

    // Main DUT (SCALE=2)
    logic [9:0]  vga_x, vga_y;
    logic        pix_valid;
    logic [7:0]  color_out;
    logic [15:0] stall_count;
    fb_arbiter_if #(.ADDR_W(15)) bus ();

    fb_arbiter #(.FB_W(160), .FB_H(120), .SCALE(2), .ADDR_W(15)) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .pix_valid   (pix_valid),
        .color_out   (color_out),
        .stall_count (stall_count),
        .bus         (bus)
    );

    // Second DUT (SCALE=0) for the stall/priority corner case
    logic [9:0]  vga0_x, vga0_y;
    logic        pix0_valid;
    logic [7:0]  color0_out;
    logic [15:0] stall0_count;
    fb_arbiter_if #(.ADDR_W(15)) bus0 ();

    fb_arbiter #(.FB_W(160), .FB_H(120), .SCALE(0), .ADDR_W(15)) u_dut0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .vga_x       (vga0_x),
        .vga_y       (vga0_y),
        .pix_valid   (pix0_valid),
        .color_out   (color0_out),
        .stall_count (stall0_count),
        .bus         (bus0)
    );

    // RAM models: read-first single port; addresses past the framebuffer
    // return 0x77 so a forced-zero read is observable.
    logic [7:0] mem  [0:32767];
    logic [7:0] mem0 [0:32767];

    always @(posedge clock) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= (bus.ram_addr >= 15'd19200) ? 8'h77 : mem[bus.ram_addr];
    end

    always @(posedge clock) begin
        if (bus0.ram_we) mem0[bus0.ram_addr] <= bus0.ram_wdata;
        bus0.ram_rdata <= (bus0.ram_addr >= 15'd19200) ? 8'h77 : mem0[bus0.ram_addr];
    end

`ifdef FB_PERF_CNT_EN
    localparam logic [15:0] STALL_EXP = 16'd10;
`else
    localparam logic [15:0] STALL_EXP = 16'd0;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0] rd_q [$];
    logic [7:0] px_q [$];

    typedef struct {
        logic       pv;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] color;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(input string name);
        for (int i = 0; i < 20 && !bus.cpu_ack; i++) tick();
        if (!bus.cpu_ack) check(name, 32'(bus.cpu_ack), 32'd1);
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        wait_ack("wr_ack_timeout");
        tick();
        bus.cpu_req = 1'b0;
    endtask

    task automatic cpu_read(input logic [14:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = a;
        wait_ack("rd_ack_timeout");
        check("rd_data", 32'(bus.cpu_rdata), 32'(rd_q.pop_front()));
        tick();
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       fetch;
        logic [14:0] exp_addr;

        vecs[0]  = '{1'b1, 10'd0,   10'd0,   8'hE0};
        vecs[1]  = '{1'b1, 10'd1,   10'd0,   8'hE0};
        vecs[2]  = '{1'b1, 10'd2,   10'd0,   8'hE0};
        vecs[3]  = '{1'b1, 10'd3,   10'd0,   8'hE0};
        vecs[4]  = '{1'b1, 10'd4,   10'd0,   8'h03};
        vecs[5]  = '{1'b1, 10'd5,   10'd0,   8'h03};
        vecs[6]  = '{1'b0, 10'd6,   10'd0,   8'h00};
        vecs[7]  = '{1'b1, 10'd7,   10'd0,   8'h03};
        vecs[8]  = '{1'b1, 10'd640, 10'd0,   8'h00};
        vecs[9]  = '{1'b1, 10'd644, 10'd0,   8'h00};
        vecs[10] = '{1'b1, 10'd4,   10'd4,   8'h1C};
        vecs[11] = '{1'b1, 10'd6,   10'd5,   8'h1C};
        vecs[12] = '{1'b1, 10'd0,   10'd480, 8'h00};
        vecs[13] = '{1'b1, 10'd0,   10'd0,   8'hE0};

        reset_n        = 1'b0;
        pix_valid      = 1'b0;
        vga_x          = '0;
        vga_y          = '0;
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = 1'b1;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = 8'hE0;
        pix0_valid     = 1'b0;
        vga0_x         = '0;
        vga0_y         = '0;
        bus0.cpu_req   = 1'b0;
        bus0.cpu_we    = 1'b0;
        bus0.cpu_addr  = '0;
        bus0.cpu_wdata = '0;

        // Reset held 3 cycles with a pending write request
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ram_we", 32'(bus.ram_we), 32'd0);
            check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
            check("rst_color", 32'(color_out), 32'h00);
            check("rst_rdata", 32'(bus.cpu_rdata), 32'h00);
            check("rst_stall", 32'(stall_count), 32'd0);
        end

        // Write during blanking: grant in the first cycle out of reset
        reset_n = 1'b1;
        #1;
        check("wr_g_we", 32'(bus.ram_we), 32'd1);
        check("wr_g_addr", 32'(bus.ram_addr), 32'd0);
        check("wr_g_wdata", 32'(bus.ram_wdata), 32'hE0);
        check("wr_g_ack", 32'(bus.cpu_ack), 32'd0);
        tick();
        check("wr_g1_ack", 32'(bus.cpu_ack), 32'd1);
        check("wr_g1_no_regrant", 32'(bus.ram_we), 32'd0);
        tick();
        bus.cpu_req = 1'b0;
        #1;
        check("wr_g2_ack", 32'(bus.cpu_ack), 32'd0);

        cpu_write(15'd1, 8'h03);
        cpu_write(15'd161, 8'h1C);

        // Pixel table; colors scored 2 cycles after the coordinates
        for (int i = 0; i < 14; i++) begin
            pix_valid = vecs[i].pv;
            vga_x     = vecs[i].x;
            vga_y     = vecs[i].y;
            px_q.push_back(vecs[i].color);
            #1;
            fetch    = vecs[i].pv && (vecs[i].x % 4 == 0) && (vecs[i].x / 4 < 160) && (vecs[i].y / 4 < 120);
            exp_addr = 15'((vecs[i].y / 4) * 160 + vecs[i].x / 4);
            if (fetch) check($sformatf("px_addr[%0d]", i), 32'(bus.ram_addr), 32'(exp_addr));
            check($sformatf("px_we[%0d]", i), 32'(bus.ram_we), 32'd0);
            tick();
            if (px_q.size() == 2) check($sformatf("px_color[%0d]", i - 1), 32'(color_out), 32'(px_q.pop_front()));
        end
        pix_valid = 1'b0;
        tick();
        check("px_color[13]", 32'(color_out), 32'(px_q.pop_front()));

        // Contention: fetch slot wins, CPU granted the next cycle
        pix_valid     = 1'b1;
        vga_x         = 10'd4;
        vga_y         = 10'd0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 15'd200;
        bus.cpu_wdata = 8'h55;
        #1;
        check("ct_t_addr", 32'(bus.ram_addr), 32'd1);
        check("ct_t_we", 32'(bus.ram_we), 32'd0);
        tick();
        vga_x = 10'd5;
        #1;
        check("ct_t1_we", 32'(bus.ram_we), 32'd1);
        check("ct_t1_addr", 32'(bus.ram_addr), 32'd200);
        check("ct_t1_ack", 32'(bus.cpu_ack), 32'd0);
        tick();
        vga_x = 10'd6;
        #1;
        check("ct_t2_ack", 32'(bus.cpu_ack), 32'd1);
        check("ct_t2_color", 32'(color_out), 32'h03);
        tick();
        bus.cpu_req = 1'b0;
        pix_valid   = 1'b0;

        // Read in blanking: data with ack at G+2
        rd_q.push_back(8'h1C);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 15'd161;
        #1;
        check("rd_g_addr", 32'(bus.ram_addr), 32'd161);
        check("rd_g_we", 32'(bus.ram_we), 32'd0);
        tick();
        check("rd_g1_ack", 32'(bus.cpu_ack), 32'd0);
        tick();
        check("rd_g2_ack", 32'(bus.cpu_ack), 32'd1);
        check("rd_g2_data", 32'(bus.cpu_rdata), 32'(rd_q.pop_front()));
        tick();
        bus.cpu_req = 1'b0;

        cpu_read(15'd200, 8'h55);
        cpu_read(15'd0, 8'hE0);

        // Out-of-range write: no RAM write, ack timing unchanged
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 15'd19200;
        bus.cpu_wdata = 8'hAA;
        #1;
        check("oob_wr_we", 32'(bus.ram_we), 32'd0);
        tick();
        check("oob_wr_ack", 32'(bus.cpu_ack), 32'd1);
        tick();
        bus.cpu_req = 1'b0;

        // Out-of-range read returns zero even though the RAM returns 0x77
        rd_q.push_back(8'h00);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 15'd19200;
        tick();
        check("oob_rd_g1_ack", 32'(bus.cpu_ack), 32'd0);
        tick();
        check("oob_rd_ack", 32'(bus.cpu_ack), 32'd1);
        check("oob_rd_data", 32'(bus.cpu_rdata), 32'(rd_q.pop_front()));
        tick();
        bus.cpu_req = 1'b0;

        // SCALE=0: every active cycle is a fetch, CPU waits for blanking
        bus0.cpu_req   = 1'b1;
        bus0.cpu_we    = 1'b1;
        bus0.cpu_addr  = 15'd5;
        bus0.cpu_wdata = 8'h11;
        pix0_valid     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vga0_x = 10'(i);
            #1;
            check($sformatf("s0_we[%0d]", i), 32'(bus0.ram_we), 32'd0);
            check($sformatf("s0_addr[%0d]", i), 32'(bus0.ram_addr), 32'(i));
            tick();
        end
        check("s0_no_ack", 32'(bus0.cpu_ack), 32'd0);
        pix0_valid = 1'b0;
        #1;
        check("s0_grant_we", 32'(bus0.ram_we), 32'd1);
        check("s0_grant_addr", 32'(bus0.ram_addr), 32'd5);
        check("s0_stall", 32'(stall0_count), 32'(STALL_EXP));
        tick();
        check("s0_ack", 32'(bus0.cpu_ack), 32'd1);
        check("s0_stall_hold", 32'(stall0_count), 32'(STALL_EXP));
        tick();
        bus0.cpu_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
